ex_mdu: RTL and testbench

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its `ex_aluop`, `ex_reg1` and `ex_reg2` outputs. It produces 64-bit HI:LO results for MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU. It raises `stallreq` toward the pipeline control block so the ID/EX register holds the instruction while a multi-cycle operation runs.

---
 rtl/ex_mdu_pkg.sv | 32 +++
 rtl/ex_mdu_div_core.sv | 78 +++++++
 rtl/ex_mdu.sv | 153 +++++++++++++++
 tb/tb_ex_mdu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared constants for the execute-stage multiply/divide unit.
package ex_mdu_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef MDU_MACC_EN
    ST_MACC   = 2'd1,
`endif
    ST_DIV_ON = 2'd2,
    ST_DONE   = 2'd3
  } mdu_state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Iterative restoring divider: one shift-subtract step per cycle for
// DIV_ITER cycles. done is high during the final step, with quot/rem
// already carrying the final signed result of that step.
module mdu_div_core
  import ex_mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] divisor_q;
  logic              quot_neg_q;
  logic              rem_neg_q;

  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quot_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem_q, quot_q[DATA_W-1]};
    diff  = trial - {1'b0, divisor_q};
    if (!diff[DATA_W]) begin
      rem_nx  = diff[DATA_W-1:0];
      quot_nx = {quot_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_nx  = trial[DATA_W-1:0];
      quot_nx = {quot_q[DATA_W-2:0], 1'b0};
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  assign quot = quot_neg_q ? -quot_nx : quot_nx;
  assign rem  = rem_neg_q  ? -rem_nx  : rem_nx;

  // Operand capture on start, then iterate until the last step completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else if (annul) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q     <= 1'b1;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= abs_val(dividend, signed_op);
      divisor_q  <= abs_val(divisor, signed_op);
      quot_neg_q <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      rem_neg_q  <= signed_op && dividend[DATA_W-1];
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      cnt_q  <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit producing {HI,LO} results.
// Optional build macro MDU_MACC_EN enables MADD/MADDU/MSUB/MSUBU.
//
// state   | meaning
// IDLE    | accept op; MULT/MULTU answer combinationally
// MACC    | add/subtract registered product to forwarded HI:LO
// DIV_ON  | divider iterating, pipeline stalled
// DONE    | present {rem,quot} for one cycle
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [7:0]          aluop_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                valid_o,
  output logic                stallreq_o
);

  mdu_state_e          state_q;
  logic [2*DATA_W-1:0] res_q;
  logic [2*DATA_W-1:0] prod;
  logic                is_mult;
  logic                is_div;
  logic                is_macc;
  logic                prod_signed;
  logic                div_start;
  logic                div_done;
  logic [DATA_W-1:0]   div_quot;
  logic [DATA_W-1:0]   div_rem;

`ifdef MDU_MACC_EN
  logic [2*DATA_W-1:0] prod_q;
  logic                sub_q;
  assign is_macc = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                   (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
`else
  logic unused_hilo;
  assign unused_hilo = ^hilo_i;
  assign is_macc     = 1'b0;
`endif

  assign is_mult     = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign is_div      = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign prod_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MADD_OP) ||
                       (aluop_i == EXE_MSUB_OP);
  assign div_start   = (state_q == ST_IDLE) && is_div && (reg2_i != '0) && !flush;

  // 32x32 product, operands extended to full width by signedness.
  always_comb begin
    if (prod_signed)
      prod = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    else
      prod = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
  end

  mdu_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (aluop_i == EXE_DIV_OP),
    .annul     (flush),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // Output decode; flush and reset silence valid/stall in the same cycle.
  always_comb begin
    result_o   = '0;
    valid_o    = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mult) begin
          result_o = prod;
          valid_o  = 1'b1;
        end else if (is_div || is_macc) begin
          stallreq_o = 1'b1;
        end
      end
`ifdef MDU_MACC_EN
      ST_MACC: begin
        result_o = sub_q ? (hilo_i - prod_q) : (hilo_i + prod_q);
        valid_o  = 1'b1;
      end
`endif
      ST_DIV_ON: stallreq_o = 1'b1;
      ST_DONE: begin
        result_o = res_q;
        valid_o  = 1'b1;
      end
      default: ;
    endcase
    if (flush || !rst) begin
      valid_o    = 1'b0;
      stallreq_o = 1'b0;
    end
    if (!rst) result_o = '0;
  end

  // Top-level sequencing; flush wins over every transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
`ifdef MDU_MACC_EN
      prod_q  <= '0;
      sub_q   <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_div) begin
            if (reg2_i == '0) begin
              res_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_DIV_ON;
            end
          end
`ifdef MDU_MACC_EN
          else if (is_macc) begin
            prod_q  <= prod;
            sub_q   <= (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
            state_q <= ST_MACC;
          end
`endif
        end
`ifdef MDU_MACC_EN
        ST_MACC: state_q <= ST_IDLE;
`endif
        ST_DIV_ON: begin
          if (div_done) begin
            res_q   <= {div_rem, div_quot};
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  aluop = EXE_NOP_OP;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [63:0] hilo = '0;
  logic [63:0] result;
  logic        valid;
  logic        stallreq;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .aluop_i    (aluop),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .hilo_i     (hilo),
    .result_o   (result),
    .valid_o    (valid),
    .stallreq_o (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: cycle in which valid appears, whether it appears, and the value.
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hl, output int lat, output bit vexp, output logic [63:0] r);
    longint sa, sb, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 1; vexp = 1'b0; r = '0;
    case (op)
      EXE_MULT_OP:  begin lat = 1; vexp = 1; r = 64'(sa * sb); end
      EXE_MULTU_OP: begin lat = 1; vexp = 1; r = {32'd0, a} * {32'd0, b}; end
`ifdef MDU_MACC_EN
      EXE_MADD_OP:  begin lat = 2; vexp = 1; r = hl + 64'(sa * sb); end
      EXE_MADDU_OP: begin lat = 2; vexp = 1; r = hl + {32'd0, a} * {32'd0, b}; end
      EXE_MSUB_OP:  begin lat = 2; vexp = 1; r = hl - 64'(sa * sb); end
      EXE_MSUBU_OP: begin lat = 2; vexp = 1; r = hl - {32'd0, a} * {32'd0, b}; end
`endif
      EXE_DIV_OP: begin
        vexp = 1;
        if (b == 0) begin lat = 2; r = '0; end
        else begin
          lat = 34;
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      EXE_DIVU_OP: begin
        vexp = 1;
        if (b == 0) begin lat = 2; r = '0; end
        else begin lat = 34; r = {a % b, a / b}; end
      end
      default: begin lat = 1; vexp = 0; end
    endcase
  endtask

  // Issue one op like ID/EX would: hold it while stalled, then drop to NOP.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hl);
    int lat;
    bit vexp;
    logic [63:0] r;
    model(op, a, b, hl, lat, vexp, r);
    aluop = op; reg1 = a; reg2 = b; hilo = hl;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      chk({tag, "_stall"}, {63'd0, stallreq}, {63'd0, n < lat});
      if (n < lat) chk({tag, "_early_valid"}, {63'd0, valid}, 64'd0);
      else begin
        chk({tag, "_valid"}, {63'd0, valid}, {63'd0, vexp});
        if (vexp) chk({tag, "_result"}, result, r);
      end
      @(posedge clk); #1;
      if (n < lat) begin reg1 = $urandom; reg2 = $urandom; end
    end
    aluop = EXE_NOP_OP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] ops [9];
    ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP,
            EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP};

    // Outputs must read zero while reset is held, even with a MULT presented.
    aluop = EXE_MULT_OP; reg1 = 32'd3; reg2 = 32'd3;
    #12;
    chk("reset_result", result, 64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    aluop = EXE_NOP_OP;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg", EXE_MULT_OP, 32'hFFFF_FFFE, 32'h0000_0003, 64'd0);
    run_op("multu", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    run_op("maddu", EXE_MADDU_OP, 32'd4, 32'd5, 64'h10);
    run_op("msub", EXE_MSUB_OP, 32'd4, 32'd5, 64'h10);
    run_op("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 64'd0);
    run_op("divu", EXE_DIVU_OP, 32'd100, 32'd7, 64'd0);
    run_op("div_zero", EXE_DIV_OP, 32'd5, 32'd0, 64'd0);
    run_op("divu_zero", EXE_DIVU_OP, 32'hDEAD_BEEF, 32'd0, 64'd0);
    run_op("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    run_op("nop", EXE_NOP_OP, 32'd1, 32'd2, 64'd0);

    // Flush at divider iteration 10 (cycle 12 of the op).
    aluop = EXE_DIV_OP; reg1 = 32'd1000; reg2 = 32'd7;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      chk("flush_pre_stall", {63'd0, stallreq}, 64'd1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {63'd0, stallreq}, 64'd0);
    chk("flush_valid", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; aluop = EXE_NOP_OP;
    @(negedge clk);
    chk("post_flush_stall", {63'd0, stallreq}, 64'd0);
    chk("post_flush_valid", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    run_op("multu_after_flush", EXE_MULTU_OP, 32'd3, 32'd3, 64'd0);
    for (int i = 0; i < 3; i++) run_op("idle_after_flush", EXE_NOP_OP, 32'd0, 32'd0, 64'd0);

    // Back-to-back divides, reset dropped mid-way through the second.
    run_op("div_first", EXE_DIV_OP, 32'hFFFF_FFEC, 32'd3, 64'd0);
    aluop = EXE_DIV_OP; reg1 = 32'd77; reg2 = 32'd5;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk("div_second_stall", {63'd0, stallreq}, 64'd1);
      chk("div_second_valid", {63'd0, valid}, 64'd0);
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_valid", {63'd0, valid}, 64'd0);
    chk("async_rst_stall", {63'd0, stallreq}, 64'd0);
    aluop = EXE_NOP_OP;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op("idle_after_rst", EXE_NOP_OP, 32'd0, 32'd0, 64'd0);
    run_op("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 64'd0);

    // Randomized mix with divider corner cases sprinkled in.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int sel;
      op  = ops[$urandom_range(0, 8)];
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) a = 32'($urandom_range(0, 50));
      run_op("rand", op, a, b, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
